id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- Pipeline stage directly downstream of the register file's read ports.
- Drives the read addresses, captures the rs1/rs2 read data into the ID/EX pipeline register, and resolves RAW hazards by forwarding from the MEM and WB stages or by stalling.
- Presents a valid/ready handshake to decode upstream and to execute downstream.
- Includes a saturating stall-cycle counter for performance visibility.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 32, width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- id_valid_i  in  1  decode presents an instruction.
- id_ready_o  out  1  stage accepts the decode instruction this cycle.
- id_pc_i  in  XLEN  instruction PC.
- id_rs1_addr_i  in  5  source register 1.
- id_rs2_addr_i  in  5  source register 2.
- id_rd_addr_i  in  5  destination register.
- id_imm_i  in  XLEN  decoded immediate.
- id_uses_rs1_i  in  1  instruction reads rs1.
- id_uses_rs2_i  in  1  instruction reads rs2.
- id_is_load_i  in  1  instruction is a load.
- rf_rs1_addr_o  out  5  register file read address 1; combinational copy of id_rs1_addr_i.
- rf_rs2_addr_o  out  5  register file read address 2; combinational copy of id_rs2_addr_i.
- rf_rs1_rdata_i  in  XLEN  register file read data 1; combinational, pre-write value.
- rf_rs2_rdata_i  in  XLEN  register file read data 2; combinational, pre-write value.
- mem_valid_i  in  1  MEM stage holds a valid instruction.
- mem_rd_addr_i  in  5  MEM stage destination register.
- mem_rd_data_i  in  XLEN  MEM stage ALU result.
- mem_is_load_i  in  1  MEM stage instruction is a load; its data is not yet available.
- wb_valid_i  in  1  WB stage is writing the register file this cycle.
- wb_rd_addr_i  in  5  WB destination register; same value as the register file write address.
- wb_rd_data_i  in  XLEN  WB write data.
- flush_i  in  1  kill the instruction in this stage.
- ex_valid_o  out  1  ID/EX register holds a valid instruction.
- ex_ready_i  in  1  execute consumes the instruction this cycle.
- ex_pc_o  out  XLEN  registered PC.
- ex_rs1_data_o  out  XLEN  registered resolved operand 1.
- ex_rs2_data_o  out  XLEN  registered resolved operand 2.
- ex_rd_addr_o  out  5  registered destination register.
- ex_imm_o  out  XLEN  registered immediate.
- ex_is_load_o  out  1  registered load flag.
- stall_cnt_o  out  CNT_W  hazard-bubble cycle count.

Behaviour:
- Reset (rst_ni low, asynchronous): all ex_* outputs are 0 and stall_cnt_o is 0. id_ready_o follows the combinational rules below.
- Advance condition: adv = !ex_valid_o || ex_ready_i.
- Match function, per source s in {rs1, rs2}: match(stage) = uses_s && addr_s != 0 && stage_valid && stage_rd == addr_s.
- Hazard: hz = id_valid_i && any source satisfies either:
  - match(EX register), where EX stage valid is ex_valid_o and EX rd is ex_rd_addr_o; or
  - match(MEM) && mem_is_load_i.
- Operand selection per source, in priority order:
  - addr == 0 → 0.
  - match(MEM) && !mem_is_load_i → mem_rd_data_i.
  - match(WB) → wb_rd_data_i. This bypass is required because the register file writes on the same edge and its reads return the old value.
  - otherwise → rf data.
  - A source with uses_s = 0 captures the rf data unmodified.
- id_ready_o = flush_i || (adv && !hz). Combinational; no dependence on id_valid_i.
- Register update, evaluated in this priority:
  1. flush_i: ex_valid_o ← 0. The incoming instruction is consumed and dropped; other fields may be left unchanged.
  2. adv && hz: ex_valid_o ← 0 (bubble). Decode holds its instruction. stall_cnt_o increments.
  3. adv && !hz: ex_valid_o ← id_valid_i. All fields are loaded from decode and the resolved operands.
  4. !adv: all fields hold. A pending hazard does not increment the counter.
- stall_cnt_o saturates at all-ones and never wraps.
- Stall latency:
  - A dependency on the instruction in the EX register costs one bubble when it moves to a non-load MEM instruction.
  - A load-use dependency costs two bubbles: one while the load is in EX, one while it is in MEM. The operand is then forwarded from WB.
- Simultaneous MEM and WB match on the same register: MEM wins as the younger producer.
- Reset asserted mid-stall clears the state immediately. After release, the first instruction is accepted with no hazard against stale ex_rd_addr_o, because ex_valid_o is 0.

Test Plan:
- Independent instruction: rf rs1 = 0x11, rf rs2 = 0x22, no matches, ex_ready_i = 1 → next cycle ex_valid_o = 1, ex_rs1_data_o = 0x11, ex_rs2_data_o = 0x22; id_ready_o = 1 throughout.
- Forwarding priority: MEM rd = x5 with data 0xAAAA (non-load); WB rd = x5 with data 0xBBBB; WB rd = x6 with data 0xCCCC; instruction reads rs1 = x5, rs2 = x6 → captured operands 0xAAAA and 0xCCCC; no stall.
- Load-use stall: EX register holds a load to x7; next instruction reads x7 → two cycles with id_ready_o = 0 and bubbles inserted; stall_cnt_o = 2; then captures wb_rd_data_i = 0xDEAD.
- x0 handling: MEM and WB both target x0 with nonzero data, instruction reads x0 → operand = 0; no stall.
- Backpressure and flush: ex_ready_i = 0 with ex_valid_o = 1 → all ex_* outputs hold and stall_cnt_o is unchanged. Then assert flush_i → id_ready_o = 1, next cycle ex_valid_o = 0.
- Async reset: drop rst_ni mid-cycle during a stall → ex_valid_o and stall_cnt_o go to 0 immediately. Counter preset near saturation (0xFFFFFFFF) plus one more stall → stays 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: drives register file reads, resolves RAW hazards by MEM/WB forwarding
// or stalling, and registers the resolved operands for execute behind a valid/ready handshake.
module id_ex_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_is_load_i,
    output logic [4:0]       rf_rs1_addr_o,
    output logic [4:0]       rf_rs2_addr_o,
    input  logic [XLEN-1:0]  rf_rs1_rdata_i,
    input  logic [XLEN-1:0]  rf_rs2_rdata_i,
    input  logic             mem_valid_i,
    input  logic [4:0]       mem_rd_addr_i,
    input  logic [XLEN-1:0]  mem_rd_data_i,
    input  logic             mem_is_load_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_addr_i,
    input  logic [XLEN-1:0]  wb_rd_data_i,
    input  logic             flush_i,
    output logic             ex_valid_o,
    input  logic             ex_ready_i,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic [4:0]       ex_rd_addr_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic             ex_is_load_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic             ex_valid_q;
    logic [XLEN-1:0]  ex_pc_q;
    logic [XLEN-1:0]  ex_rs1_q;
    logic [XLEN-1:0]  ex_rs2_q;
    logic [4:0]       ex_rd_q;
    logic [XLEN-1:0]  ex_imm_q;
    logic             ex_is_load_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic            adv;
    logic            hz;
    logic            rs1_ex, rs1_mem, rs1_wb;
    logic            rs2_ex, rs2_mem, rs2_wb;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    function automatic logic src_match(input logic uses, input logic [4:0] addr,
                                       input logic vld, input logic [4:0] rd);
        return uses && (addr != 5'd0) && vld && (rd == addr);
    endfunction

    assign rf_rs1_addr_o = id_rs1_addr_i;
    assign rf_rs2_addr_o = id_rs2_addr_i;

    assign rs1_ex  = src_match(id_uses_rs1_i, id_rs1_addr_i, ex_valid_q, ex_rd_q);
    assign rs1_mem = src_match(id_uses_rs1_i, id_rs1_addr_i, mem_valid_i, mem_rd_addr_i);
    assign rs1_wb  = src_match(id_uses_rs1_i, id_rs1_addr_i, wb_valid_i, wb_rd_addr_i);
    assign rs2_ex  = src_match(id_uses_rs2_i, id_rs2_addr_i, ex_valid_q, ex_rd_q);
    assign rs2_mem = src_match(id_uses_rs2_i, id_rs2_addr_i, mem_valid_i, mem_rd_addr_i);
    assign rs2_wb  = src_match(id_uses_rs2_i, id_rs2_addr_i, wb_valid_i, wb_rd_addr_i);

    assign adv = !ex_valid_q || ex_ready_i;
    assign hz  = id_valid_i && (rs1_ex || rs2_ex ||
                                ((rs1_mem || rs2_mem) && mem_is_load_i));
    assign id_ready_o = flush_i || (adv && !hz);

    // MEM beats WB: it holds the younger write to the same register.
    always_comb begin
        rs1_fwd = rf_rs1_rdata_i;
        if (id_uses_rs1_i) begin
            if (id_rs1_addr_i == 5'd0)          rs1_fwd = '0;
            else if (rs1_mem && !mem_is_load_i) rs1_fwd = mem_rd_data_i;
            else if (rs1_wb)                    rs1_fwd = wb_rd_data_i;
        end
    end

    always_comb begin
        rs2_fwd = rf_rs2_rdata_i;
        if (id_uses_rs2_i) begin
            if (id_rs2_addr_i == 5'd0)          rs2_fwd = '0;
            else if (rs2_mem && !mem_is_load_i) rs2_fwd = mem_rd_data_i;
            else if (rs2_wb)                    rs2_fwd = wb_rd_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_imm_q     <= '0;
            ex_is_load_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
        end else if (adv) begin
            if (hz) begin
                ex_valid_q <= 1'b0;
                if (stall_cnt_q != '1) begin
                    stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                ex_valid_q   <= id_valid_i;
                ex_pc_q      <= id_pc_i;
                ex_rs1_q     <= rs1_fwd;
                ex_rs2_q     <= rs2_fwd;
                ex_rd_q      <= id_rd_addr_i;
                ex_imm_q     <= id_imm_i;
                ex_is_load_q <= id_is_load_i;
            end
        end
    end

    assign ex_valid_o    = ex_valid_q;
    assign ex_pc_o       = ex_pc_q;
    assign ex_rs1_data_o = ex_rs1_q;
    assign ex_rs2_data_o = ex_rs2_q;
    assign ex_rd_addr_o  = ex_rd_q;
    assign ex_imm_o      = ex_imm_q;
    assign ex_is_load_o  = ex_is_load_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed vectors push expected EX records, a monitor
// pops them as execute consumes; a narrow-counter twin exercises stall counter saturation.
module tb_id_ex_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        id_valid_i, id_uses_rs1_i, id_uses_rs2_i, id_is_load_i;
    logic [31:0] id_pc_i, id_imm_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [31:0] rf_rs1_rdata_i, rf_rs2_rdata_i;
    logic        mem_valid_i, mem_is_load_i;
    logic [4:0]  mem_rd_addr_i;
    logic [31:0] mem_rd_data_i;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic        flush_i, ex_ready_i;

    logic        id_ready_o, ex_valid_o, ex_is_load_o;
    logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o, ex_rd_addr_o;
    logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, stall_cnt_o;

    logic        s_id_ready, s_ex_valid, s_ex_is_load;
    logic [4:0]  s_rf1, s_rf2, s_ex_rd;
    logic [31:0] s_ex_pc, s_ex_rs1, s_ex_rs2, s_ex_imm;
    logic [1:0]  s_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_operand_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_imm_i(id_imm_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_is_load_i(id_is_load_i),
        .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
        .rf_rs1_rdata_i(rf_rs1_rdata_i), .rf_rs2_rdata_i(rf_rs2_rdata_i),
        .mem_valid_i(mem_valid_i), .mem_rd_addr_i(mem_rd_addr_i),
        .mem_rd_data_i(mem_rd_data_i), .mem_is_load_i(mem_is_load_i),
        .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
        .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_imm_o(ex_imm_o), .ex_is_load_o(ex_is_load_o),
        .stall_cnt_o(stall_cnt_o)
    );

    // Same stimulus, 2-bit counter: saturates at 3 within a short run.
    id_ex_operand_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_valid_i(id_valid_i), .id_ready_o(s_id_ready), .id_pc_i(id_pc_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_imm_i(id_imm_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_is_load_i(id_is_load_i),
        .rf_rs1_addr_o(s_rf1), .rf_rs2_addr_o(s_rf2),
        .rf_rs1_rdata_i(rf_rs1_rdata_i), .rf_rs2_rdata_i(rf_rs2_rdata_i),
        .mem_valid_i(mem_valid_i), .mem_rd_addr_i(mem_rd_addr_i),
        .mem_rd_data_i(mem_rd_data_i), .mem_is_load_i(mem_is_load_i),
        .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
        .flush_i(flush_i), .ex_valid_o(s_ex_valid), .ex_ready_i(ex_ready_i),
        .ex_pc_o(s_ex_pc), .ex_rs1_data_o(s_ex_rs1), .ex_rs2_data_o(s_ex_rs2),
        .ex_rd_addr_o(s_ex_rd), .ex_imm_o(s_ex_imm), .ex_is_load_o(s_ex_is_load),
        .stall_cnt_o(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [31:0] imm, input logic u1,
                          input logic u2, input logic ld);
        id_valid_i = 1'b1; id_pc_i = pc; id_rs1_addr_i = a1; id_rs2_addr_i = a2;
        id_rd_addr_i = rd; id_imm_i = imm; id_uses_rs1_i = u1; id_uses_rs2_i = u2;
        id_is_load_i = ld;
    endtask

    task automatic set_rf(input logic [31:0] d1, input logic [31:0] d2);
        rf_rs1_rdata_i = d1; rf_rs2_rdata_i = d2;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] rd, input logic [31:0] d,
                           input logic ld);
        mem_valid_i = v; mem_rd_addr_i = rd; mem_rd_data_i = d; mem_is_load_i = ld;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid_i = v; wb_rd_addr_i = rd; wb_rd_data_i = d;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] rd, input logic [31:0] imm, input logic ld);
        exp_t e;
        e.pc = pc; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = imm; e.ld = ld;
        sb.push_back(e);
    endtask

    // Monitor: every instruction execute consumes must match the oldest expected record.
    always @(negedge clk_i) begin
        if (rst_ni && ex_valid_o && ex_ready_i) begin
            exp_t e;
            exp_t a;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow actual pc=%0h required=no output", ex_pc_o);
            end else begin
                e = sb.pop_front();
                a.pc = ex_pc_o; a.rs1 = ex_rs1_data_o; a.rs2 = ex_rs2_data_o;
                a.rd = ex_rd_addr_o; a.imm = ex_imm_o; a.ld = ex_is_load_o;
                if (a !== e) begin
                    errors++;
                    $display("FAIL ex_record actual pc=%0h rs1=%0h rs2=%0h rd=%0d imm=%0h ld=%0b required pc=%0h rs1=%0h rs2=%0h rd=%0d imm=%0h ld=%0b",
                             a.pc, a.rs1, a.rs2, a.rd, a.imm, a.ld,
                             e.pc, e.rs1, e.rs2, e.rd, e.imm, e.ld);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        id_valid_i = 0; id_pc_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
        id_imm_i = 0; id_uses_rs1_i = 0; id_uses_rs2_i = 0; id_is_load_i = 0;
        set_rf(0, 0); set_mem(0, 0, 0, 0); set_wb(0, 0, 0);
        flush_i = 0; ex_ready_i = 1;

        smp();
        chk("rst_ex_valid", ex_valid_o, 0);
        chk("rst_ex_pc", ex_pc_o, 0);
        chk("rst_ex_rs1", ex_rs1_data_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_id_ready", id_ready_o, 1);
        next();
        rst_ni = 1'b1;

        // Independent instruction
        set_rf(32'h11, 32'h22);
        set_id(32'h100, 5'd1, 5'd2, 5'd3, 32'h5, 1, 1, 0);
        push(32'h100, 32'h11, 32'h22, 5'd3, 32'h5, 0);
        smp();
        chk("indep_id_ready", id_ready_o, 1);
        chk("rf_rs1_addr", rf_rs1_addr_o, 1);
        chk("rf_rs2_addr", rf_rs2_addr_o, 2);
        next();

        // MEM and WB both target x5: MEM wins
        set_mem(1, 5'd5, 32'hAAAA, 0); set_wb(1, 5'd5, 32'hBBBB); set_rf(32'h55, 32'h55);
        set_id(32'h104, 5'd5, 5'd5, 5'd8, 32'h0, 1, 1, 0);
        push(32'h104, 32'hAAAA, 32'hAAAA, 5'd8, 32'h0, 0);
        smp();
        chk("fwd_mem_wb_id_ready", id_ready_o, 1);
        next();

        // MEM x5, WB x6
        set_wb(1, 5'd6, 32'hCCCC); set_rf(32'h55, 32'h66);
        set_id(32'h108, 5'd5, 5'd6, 5'd9, 32'h0, 1, 1, 0);
        push(32'h108, 32'hAAAA, 32'hCCCC, 5'd9, 32'h0, 0);
        smp();
        chk("fwd_split_id_ready", id_ready_o, 1);
        next();

        // Unused sources: rf data kept, no load hazard
        set_mem(1, 5'd5, 32'hAAAA, 1);
        set_id(32'h10C, 5'd5, 5'd6, 5'd10, 32'h0, 0, 0, 0);
        push(32'h10C, 32'h55, 32'h66, 5'd10, 32'h0, 0);
        smp();
        chk("unused_src_id_ready", id_ready_o, 1);
        next();

        // x0 reads ignore MEM/WB writes to x0
        set_mem(1, 5'd0, 32'h1234, 1); set_wb(1, 5'd0, 32'h5678); set_rf(32'h99, 32'h99);
        set_id(32'h110, 5'd0, 5'd0, 5'd11, 32'h7, 1, 1, 0);
        push(32'h110, 32'h0, 32'h0, 5'd11, 32'h7, 0);
        smp();
        chk("x0_id_ready", id_ready_o, 1);
        chk("x0_stall_cnt", stall_cnt_o, 0);
        next();

        // EX dependency on a non-load: one bubble
        set_mem(0, 0, 0, 0); set_wb(0, 0, 0); set_rf(32'h11, 32'h22);
        set_id(32'h200, 5'd1, 5'd2, 5'd12, 32'h0, 1, 1, 0);
        push(32'h200, 32'h11, 32'h22, 5'd12, 32'h0, 0);
        smp();
        chk("exdep_prod_id_ready", id_ready_o, 1);
        next();
        set_id(32'h204, 5'd12, 5'd2, 5'd13, 32'h0, 1, 1, 0);
        smp();
        chk("exdep_stall_id_ready", id_ready_o, 0);
        next();
        set_mem(1, 5'd12, 32'h1212, 0);
        push(32'h204, 32'h1212, 32'h22, 5'd13, 32'h0, 0);
        smp();
        chk("exdep_resume_id_ready", id_ready_o, 1);
        chk("exdep_stall_cnt", stall_cnt_o, 1);
        next();

        // Load-use: two bubbles, then WB forward
        set_mem(0, 0, 0, 0);
        set_id(32'h300, 5'd1, 5'd2, 5'd7, 32'h8, 1, 1, 1);
        push(32'h300, 32'h11, 32'h22, 5'd7, 32'h8, 1);
        smp();
        chk("ld_prod_id_ready", id_ready_o, 1);
        next();
        set_id(32'h304, 5'd7, 5'd2, 5'd14, 32'h0, 1, 1, 0);
        smp();
        chk("ld_use_ex_id_ready", id_ready_o, 0);
        next();
        set_mem(1, 5'd7, 32'hBAD, 1);
        smp();
        chk("ld_use_mem_id_ready", id_ready_o, 0);
        chk("ld_use_bubble", ex_valid_o, 0);
        next();
        set_mem(0, 0, 0, 0); set_wb(1, 5'd7, 32'hDEAD);
        push(32'h304, 32'hDEAD, 32'h22, 5'd14, 32'h0, 0);
        smp();
        chk("ld_use_wb_id_ready", id_ready_o, 1);
        chk("ld_use_stall_cnt", stall_cnt_o, 3);
        chk("sat_cnt_at_3", {30'd0, s_cnt}, 3);
        next();

        // Backpressure holds everything, then flush drops the held instruction
        set_wb(0, 0, 0);
        set_id(32'h400, 5'd1, 5'd2, 5'd15, 32'h44, 1, 1, 0);
        push(32'h400, 32'h11, 32'h22, 5'd15, 32'h44, 0);
        smp();
        chk("bp_prod_id_ready", id_ready_o, 1);
        next();
        ex_ready_i = 0; set_rf(32'h77, 32'h77);
        set_id(32'h404, 5'd3, 5'd4, 5'd16, 32'h0, 1, 1, 0);
        smp();
        chk("bp_id_ready", id_ready_o, 0);
        chk("bp_ex_valid", ex_valid_o, 1);
        chk("bp_ex_pc", ex_pc_o, 32'h400);
        chk("bp_ex_rs1", ex_rs1_data_o, 32'h11);
        next();
        set_id(32'h404, 5'd15, 5'd4, 5'd16, 32'h0, 1, 1, 0);
        smp();
        chk("bp_hz_id_ready", id_ready_o, 0);
        chk("bp_hold_pc", ex_pc_o, 32'h400);
        chk("bp_hold_rs2", ex_rs2_data_o, 32'h22);
        chk("bp_hold_imm", ex_imm_o, 32'h44);
        chk("bp_hold_rd", ex_rd_addr_o, 15);
        next();
        flush_i = 1;
        smp();
        chk("bp_stall_cnt_held", stall_cnt_o, 3);
        chk("flush_id_ready", id_ready_o, 1);
        void'(sb.pop_front());
        next();
        flush_i = 0; ex_ready_i = 1; id_valid_i = 0;
        smp();
        chk("flush_ex_valid", ex_valid_o, 0);
        chk("idle_id_ready", id_ready_o, 1);
        next();

        // Fourth stall: wide counter keeps counting, narrow one stays saturated
        set_rf(32'h11, 32'h22);
        set_id(32'h500, 5'd1, 5'd2, 5'd17, 32'h0, 1, 1, 0);
        push(32'h500, 32'h11, 32'h22, 5'd17, 32'h0, 0);
        smp();
        chk("sat_prod_id_ready", id_ready_o, 1);
        next();
        set_id(32'h504, 5'd17, 5'd2, 5'd18, 32'h0, 1, 1, 0);
        smp();
        chk("sat_stall_id_ready", id_ready_o, 0);
        next();
        push(32'h504, 32'h11, 32'h22, 5'd18, 32'h0, 0);
        smp();
        chk("sat_stall_cnt", stall_cnt_o, 4);
        chk("sat_cnt_held", {30'd0, s_cnt}, 3);
        chk("sat_resume_id_ready", id_ready_o, 1);
        next();

        // Async reset during a stall with a valid instruction in EX
        set_id(32'h508, 5'd18, 5'd2, 5'd19, 32'h0, 1, 1, 0);
        smp();
        chk("rst_stall_id_ready", id_ready_o, 0);
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_ex_valid", ex_valid_o, 0);
        chk("async_rst_stall_cnt", stall_cnt_o, 0);
        chk("async_rst_sat_cnt", {30'd0, s_cnt}, 0);
        chk("async_rst_ex_rd", ex_rd_addr_o, 0);
        next();
        rst_ni = 1'b1;
        set_id(32'h600, 5'd18, 5'd2, 5'd20, 32'h0, 1, 1, 0);
        push(32'h600, 32'h11, 32'h22, 5'd20, 32'h0, 0);
        smp();
        chk("post_rst_id_ready", id_ready_o, 1);
        next();
        id_valid_i = 0;
        next();
        next();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
